// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants, field widths and the 12 h display mapping
// for the rtc_timekeeper block.
//   SEC_W/MIN_W/HR_W      : widths of the seconds/minutes/hours fields
//   SEC_MAX/MIN_MAX/HR_MAX: terminal values of each time field
//   HR_NOON               : first afternoon hour (12)
package rtc_pkg;

    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [HR_W-1:0]  HR_NOON = 5'd12;

    // 24 h -> 12 h: 0 -> 12, 1..12 unchanged, 13..23 -> 1..11.
    function automatic logic [HR_W-1:0] to_12h(input logic [HR_W-1:0] hr24);
        logic [HR_W-1:0] res;
        if (hr24 == '0) begin
            res = HR_NOON;
        end else if (hr24 > HR_NOON) begin
            res = hr24 - HR_NOON;
        end else begin
            res = hr24;
        end
        return res;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk down to one advance request per second.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; 0 holds the count
//   clear in  synchronous clear to 0 (wins over counting, acts regardless of en)
//   adv   out combinational, high while en=1 and the count is at PRESCALE-1
module rtc_prescaler #(
    parameter int unsigned PRESCALE = 100,
    parameter int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic adv
);

    localparam logic [PS_W-1:0] TERM = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_q, cnt_d;

    assign adv = en && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = adv ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: hh:mm:ss timekeeper with on-board second prescaler,
// range-checked time load, 12/24 h display and sticky hh:mm alarm.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   en                             count enable
//   set_valid, set_hr/min/sec      one-cycle time load request
//   mode_12h                       1 = disp_hr in 12 h form
//   alarm_en, alarm_hr/min         alarm arm and compare time
//   alarm_clr                      clears the sticky alarm flag
//   sec, min, hr                   current time (24 h)
//   disp_hr, pm                    display hour and afternoon flag
//   sec_tick, day_tick             registered advance / midnight strobes
//   set_err                        registered strobe for a rejected load
//   alarm                          sticky alarm flag
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned PRESCALE = 100,
    parameter int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             set_valid,
    input  logic [HR_W-1:0]  set_hr,
    input  logic [MIN_W-1:0] set_min,
    input  logic [SEC_W-1:0] set_sec,
    input  logic             mode_12h,
    input  logic             alarm_en,
    input  logic [HR_W-1:0]  alarm_hr,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic             alarm_clr,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic [HR_W-1:0]  disp_hr,
    output logic             pm,
    output logic             sec_tick,
    output logic             day_tick,
    output logic             set_err,
    output logic             alarm
);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q, hr_d;
    logic             sec_tick_q, day_tick_q, set_err_q, alarm_q, alarm_d;

    logic adv, set_ok, load, advance;
    logic sec_wrap, min_wrap, hr_wrap, alarm_hit;

    assign set_ok  = (set_hr <= HR_MAX) && (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);
    assign load    = set_valid && set_ok;
    // A valid load swallows a coincident advance; a rejected load does not.
    assign advance = adv && !load;

    rtc_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clear (load),
        .adv   (adv)
    );

    assign sec_wrap = (sec_q == SEC_MAX);
    assign min_wrap = (min_q == MIN_MAX);
    assign hr_wrap  = (hr_q == HR_MAX);

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (load) begin
            sec_d = set_sec;
            min_d = set_min;
            hr_d  = set_hr;
        end else if (advance) begin
            if (sec_wrap) begin
                sec_d = '0;
                if (min_wrap) begin
                    min_d = '0;
                    hr_d  = hr_wrap ? '0 : hr_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
    end

    // Only an advance can trigger; landing on sec 0 means the seconds wrapped.
    assign alarm_hit = advance && alarm_en && sec_wrap &&
                       (min_d == alarm_min) && (hr_d == alarm_hr);

    always_comb begin
        alarm_d = alarm_q;
        if (alarm_hit) begin
            alarm_d = 1'b1;
        end else if (alarm_clr) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            sec_tick_q <= advance;
            day_tick_q <= advance && sec_wrap && min_wrap && hr_wrap;
            set_err_q  <= set_valid && !set_ok;
            alarm_q    <= alarm_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hr       = hr_q;
    assign disp_hr  = mode_12h ? to_12h(hr_q) : hr_q;
    assign pm       = (hr_q >= HR_NOON);
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;
    assign set_err  = set_err_q;
    assign alarm    = alarm_q;

endmodule
